// File: rtl/decoder_pkg.sv
// Shared widths and types for the 3-to-8 select decoder.
package decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  // One-hot word produced by the decoder. Exactly one bit is set while the
  // decoder is enabled, and no bit is set while it is disabled.
  typedef logic [OUT_W-1:0] onehot8_t;

endpackage : decoder_pkg

// File: rtl/decoder_3to8_if.sv
// Select/decode bundle between a select source and the 3-to-8 decoder.
interface decoder_3to8_if;
  import decoder_pkg::*;

  logic             en;       // decode enable
  logic [SEL_W-1:0] a;        // binary select
  onehot8_t         s;        // combinational one-hot decode
  onehot8_t         s_q;      // registered copy of s
  logic             valid_q;  // registered copy of en

  // The select source drives en/a and consumes the decode results.
  modport master (
    output en,
    output a,
    input  s,
    input  s_q,
    input  valid_q
  );

  // The decoder consumes en/a and produces the decode results.
  modport slave (
    input  en,
    input  a,
    output s,
    output s_q,
    output valid_q
  );

endinterface : decoder_3to8_if

// File: rtl/decoder_2to4.sv
// 2-to-4 line decoder with enable, built from inverters and AND gates.
module decoder_2to4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);

  logic a0_n;
  logic a1_n;

  // Inverted select lines shared by the AND terms below.
  assign a0_n = ~a[0];
  assign a1_n = ~a[1];

  // One AND term per output line; all lines stay low while en is low.
  assign y[0] = en & a1_n & a0_n;
  assign y[1] = en & a1_n & a[0];
  assign y[2] = en & a[1] & a0_n;
  assign y[3] = en & a[1] & a[0];

endmodule : decoder_2to4

// File: rtl/decoder_3to8.sv
// Structural 3-to-8 line decoder with enable. The combinational one-hot word
// is built from two 2-to-4 decoders split on the select MSB; a registered copy
// of the word and of the enable is kept for synchronous consumers.
module decoder_3to8
  import decoder_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decoder_3to8_if.slave  bus
);

  onehot8_t s_comb;
  logic     en_lo;
  logic     en_hi;

  // The select MSB picks which half of the output word may be active.
  assign en_lo = bus.en & ~bus.a[2];
  assign en_hi = bus.en &  bus.a[2];

  // Lower half: a = 0..3 drives s[3:0].
  decoder_2to4 u_dec_lo (
    .en (en_lo),
    .a  (bus.a[1:0]),
    .y  (s_comb[3:0])
  );

  // Upper half: a = 4..7 drives s[7:4].
  decoder_2to4 u_dec_hi (
    .en (en_hi),
    .a  (bus.a[1:0]),
    .y  (s_comb[7:4])
  );

  // The combinational output ignores clk and rst entirely.
  assign bus.s = s_comb;

  // Output register: captures the decode and the enable each rising edge,
  // cleared immediately whenever rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.s_q     <= '0;
      bus.valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so both registers sample pre-edge values
      // regardless of statement order or other processes triggered by this edge.
      bus.s_q     <= s_comb;
      bus.valid_q <= bus.en;
    end
  end

endmodule : decoder_3to8

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8: decode sweep, disable, registered latency,
// asynchronous reset and a seeded sequence of (a, en) pairs.
module tb_decoder_3to8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Hand-computed decode table for en = 1, indexed by a.
  localparam logic [7:0] EXP_TBL [8] = '{
    8'b0000_0001, 8'b0000_0010, 8'b0000_0100, 8'b0000_1000,
    8'b0001_0000, 8'b0010_0000, 8'b0100_0000, 8'b1000_0000
  };

  decoder_3to8_if bus ();

  decoder_3to8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst    = 1'b0;
    bus.en = 1'b0;
    bus.a  = 3'd0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.s_q !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_s_q: got %b expected %b", bus.s_q, 8'h00);
    end
    n_tests++;
    if (bus.valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_q: got %b expected %b", bus.valid_q, 1'b0);
    end
    // Drive an active decode while reset holds across a clock edge.
    bus.en = 1'b1;
    bus.a  = 3'd3;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.s_q !== 8'h00 || bus.valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got s_q=%b valid_q=%b expected 00000000/0",
               bus.s_q, bus.valid_q);
    end
    n_tests++;
    if (bus.s !== 8'b0000_1000) begin
      n_fail++;
      $display("FAIL reset_s_comb: got %b expected %b", bus.s, 8'b0000_1000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.a = 3'(i);
      #1;
      n_tests++;
      if (bus.s !== EXP_TBL[i]) begin
        n_fail++;
        $display("FAIL sweep_a%0d: got %b expected %b", i, bus.s, EXP_TBL[i]);
      end
      n_tests++;
      if ($countones(bus.s) != 1) begin
        n_fail++;
        $display("FAIL sweep_onehot_a%0d: got %0d bits set expected 1",
                 i, $countones(bus.s));
      end
      #9;
    end
  endtask

  task automatic test_disable();
    @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.a = 3'(i);
      #1;
      n_tests++;
      if (bus.s !== 8'h00) begin
        n_fail++;
        $display("FAIL disable_a%0d: got %b expected %b", i, bus.s, 8'h00);
      end
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.s_q !== 8'h00 || bus.valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_reg: got s_q=%b valid_q=%b expected 00000000/0",
               bus.s_q, bus.valid_q);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus.en = 1'b1;
    bus.a  = 3'd5;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.s_q !== 8'b0010_0000 || bus.valid_q !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_edge_n: got s_q=%b valid_q=%b expected 00100000/1",
               bus.s_q, bus.valid_q);
    end
    bus.a = 3'd2;
    @(negedge clk);
    n_tests++;
    if (bus.s_q !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL latency_hold: got %b expected %b", bus.s_q, 8'b0010_0000);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.s_q !== 8'b0000_0100) begin
      n_fail++;
      $display("FAIL latency_edge_n1: got %b expected %b", bus.s_q, 8'b0000_0100);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.en = 1'b1;
    bus.a  = 3'd7;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.s_q !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL areset_pre: got %b expected %b", bus.s_q, 8'b1000_0000);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.s_q !== 8'h00 || bus.valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_clear: got s_q=%b valid_q=%b expected 00000000/0",
               bus.s_q, bus.valid_q);
    end
    n_tests++;
    if (bus.s !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL areset_s_comb: got %b expected %b", bus.s, 8'b1000_0000);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.s_q !== 8'h00 || bus.valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_release: got s_q=%b valid_q=%b expected 00000000/0",
               bus.s_q, bus.valid_q);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.s_q !== 8'b1000_0000 || bus.valid_q !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_first_capture: got s_q=%b valid_q=%b expected 10000000/1",
               bus.s_q, bus.valid_q);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_s;
    int         bad_comb;
    int         bad_pop;
    int         bad_reg;
    bad_comb = 0;
    bad_pop  = 0;
    bad_reg  = 0;
    void'($urandom(32'h1234_5678));
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.a  = 3'($urandom_range(0, 7));
      bus.en = 1'($urandom_range(0, 1));
      exp_s  = bus.en ? (8'h01 << bus.a) : 8'h00;
      #1;
      n_tests++;
      if (bus.s !== exp_s) begin
        n_fail++;
        bad_comb++;
        if (bad_comb <= 5)
          $display("FAIL rand_s_%0d: got %b expected %b (a=%0d en=%b)",
                   i, bus.s, exp_s, bus.a, bus.en);
      end
      n_tests++;
      if ($countones(bus.s) != int'(bus.en)) begin
        n_fail++;
        bad_pop++;
        if (bad_pop <= 5)
          $display("FAIL rand_popcount_%0d: got %0d expected %0d",
                   i, $countones(bus.s), int'(bus.en));
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.s_q !== exp_s || bus.valid_q !== bus.en) begin
        n_fail++;
        bad_reg++;
        if (bad_reg <= 5)
          $display("FAIL rand_reg_%0d: got s_q=%b valid_q=%b expected %b/%b",
                   i, bus.s_q, bus.valid_q, exp_s, bus.en);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sweep();
    test_disable();
    test_latency();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_decoder_3to8

// File: doc/decoder_3to8.md
# decoder_3to8

Structural 3-to-8 line decoder with enable. It converts a 3-bit binary select into a one-hot 8-bit word and is the basic address/select decoder used by the structural datapath. It provides a combinational output for immediate use and a registered copy for synchronous consumers.

## Interface
Parameters:
- None. Widths are fixed: 3 select bits, 8 outputs.

Ports:
- clk  input  1  system clock; the registered output updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high; clears the registered output.
- en  input  1  decode enable; when low, all outputs are deasserted.
- a  input  3  binary select, unsigned, range 0–7.
- s  output  8  combinational one-hot decode: s[i] = en & (a == i).
- s_q  output  8  registered copy of s.
- valid_q  output  1  registered copy of en.

## Operation
- Combinational path:
  - s = 8'b0000_0001 << a when en = 1.
  - s = 8'b0000_0000 when en = 0.
  - Exactly one bit of s is set while en = 1. No bits are set while en = 0.
- Decode mapping with en = 1:
  - a = 000 → s = 00000001
  - a = 001 → s = 00000010
  - a = 010 → s = 00000100
  - a = 011 → s = 00001000
  - a = 100 → s = 00010000
  - a = 101 → s = 00100000
  - a = 110 → s = 01000000
  - a = 111 → s = 10000000
- Registered path:
  - On each rising edge of clk with rst low: s_q ← s and valid_q ← en.
  - While rst = 1: s_q = 8'h00 and valid_q = 0, regardless of clk.
- X or Z on a does not need defined behaviour. A bench may only drive known values.
- The combinational path s ignores rst and clk entirely.

## Timing
- s: zero-cycle latency; settles within the same delta/propagation time as any change on a or en.
- s_q and valid_q: one-cycle latency. They reflect a and en as sampled at the preceding rising clk edge.
- Reset values: s_q = 00000000 and valid_q = 0.
  - Assertion takes effect immediately, with no clock required.
  - After deassertion, the first capture happens at the next rising edge.
- Reset asserted mid-operation clears s_q and valid_q at once. s keeps tracking a and en.
- If a changes simultaneously with a clk edge, s_q captures the pre-edge value. Standard setup/hold applies.
- No handshake and no back-pressure. The block is always ready.

## Structure
- The shared package `decoder_pkg` holds:
  - SEL_W = 3
  - OUT_W = 8
  - the one-hot typedef `onehot8_t`
- Natural sub-module: `decoder_2to4`, which takes a[1:0] and an enable and produces 4 one-hot outputs. It is built from NOT/AND gates.
- Top level uses two decoder_2to4 instances:
  - The low instance is enabled by en & ~a[2] and drives s[3:0].
  - The high instance is enabled by en & a[2] and drives s[7:4].
- The output register (s_q, valid_q) is a separate always block in the top level, with asynchronous reset.

## Test plan
- Sweep: en = 1, a = 0..7 with 10 time units each → s = 1 << a each step (00000001 … 10000000), and exactly one bit set every step.
- Disable: en = 0 for every value of a → s = 00000000; after the next clk edge, s_q = 00000000 and valid_q = 0.
- Registered latency:
  - en = 1, a = 5 before edge N → s_q = 00100000 and valid_q = 1 after edge N.
  - Change a to 2 between edges → s_q holds 00100000 until edge N+1, then becomes 00000100.
- Async reset:
  - Assert rst between clock edges while s_q = 10000000 → s_q = 00000000 and valid_q = 0 immediately. s still equals 1 << a.
  - Deassert rst → the first capture occurs at the following rising edge.
- One-hot invariant, randomized: 200 random (a, en) pairs. Check popcount(s) == en and s == (en ? 1 << a : 0). Check s_q equals the previous cycle's s.
